// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
// The performance-counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        clr;
    logic [5:0]  stall;
    logic [1:0]  state;
    logic [15:0] stall_len;
    logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] id_stall_cnt;
    logic [31:0] ex_stall_cnt;

    modport master (
        output stallreq_from_id, stallreq_from_ex, clr,
        input  stall, state, stall_len, stall_timeout, id_stall_cnt, ex_stall_cnt
    );
    modport slave (
        input  stallreq_from_id, stallreq_from_ex, clr,
        output stall, state, stall_len, stall_timeout, id_stall_cnt, ex_stall_cnt
    );
`else
    modport master (
        output stallreq_from_id, stallreq_from_ex, clr,
        input  stall, state, stall_len, stall_timeout
    );
    modport slave (
        input  stallreq_from_id, stallreq_from_ex, clr,
        output stall, state, stall_len, stall_timeout
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: combinational per-stage hold, stall-run tracking, watchdog.
// Optional per-source stall counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int WDOG_LIMIT = 64
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        STALL_ID = 2'b01,
        STALL_EX = 2'b10
    } state_t;

    localparam logic [15:0] WDOG_LIMIT_W = 16'(WDOG_LIMIT);

    logic        id_req;
    logic        ex_req;
    logic        any_req;
    state_t      state_reg;
    state_t      state_next;
    logic [15:0] stall_len_reg;
    logic [15:0] stall_len_next;
    logic        timeout_reg;

    assign id_req  = bus.stallreq_from_id;
    assign ex_req  = bus.stallreq_from_ex;
    assign any_req = id_req | ex_req;

    // EX holds PC..EX/MEM (bits 0..3), ID holds PC..ID/EX (bits 0..2); reset masks everything.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_stall
            localparam bit HELD_BY_EX = (gi <= 3);
            localparam bit HELD_BY_ID = (gi <= 2);
            assign bus.stall[gi] = !rst && ((ex_req && HELD_BY_EX) || (id_req && HELD_BY_ID));
        end
    endgenerate

    always_comb begin
        state_next = RUN;
        if (ex_req)
            state_next = STALL_EX;
        else if (id_req)
            state_next = STALL_ID;
    end

    always_comb begin
        stall_len_next = '0;
        if (any_req)
            stall_len_next = (stall_len_reg == 16'hFFFF) ? 16'hFFFF : stall_len_reg + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            stall_len_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stall_len_reg <= stall_len_next;
            // clr wins over a same-cycle watchdog hit; the flag is otherwise sticky
            if (bus.clr)
                timeout_reg <= 1'b0;
            else if (any_req && (stall_len_next == WDOG_LIMIT_W))
                timeout_reg <= 1'b1;
        end
    end

    assign bus.state         = state_reg;
    assign bus.stall_len     = stall_len_reg;
    assign bus.stall_timeout = timeout_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] id_cnt_reg;
    logic [31:0] ex_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            id_cnt_reg <= '0;
            ex_cnt_reg <= '0;
        end else if (ex_req) begin
            if (ex_cnt_reg != 32'hFFFF_FFFF)
                ex_cnt_reg <= ex_cnt_reg + 32'd1;
        end else if (id_req) begin
            if (id_cnt_reg != 32'hFFFF_FFFF)
                id_cnt_reg <= id_cnt_reg + 32'd1;
        end
    end

    assign bus.id_stall_cnt = id_cnt_reg;
    assign bus.ex_stall_cnt = ex_cnt_reg;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a run-length reference model.
module tb_pipe_ctrl;
    localparam int WDOG = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl #(.WDOG_LIMIT(WDOG)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // reference model state
    int     m_len;
    int     m_state;
    bit     m_to;
    longint m_id;
    longint m_ex;
    logic [5:0] obs_stall;
    logic [5:0] exp_stall;

    task automatic apply(input bit id, input bit ex, input bit c, input bit r);
        @(negedge clk);
        bus.stallreq_from_id = id;
        bus.stallreq_from_ex = ex;
        bus.clr              = c;
        rst                  = r;
        #1;
        obs_stall = bus.stall;
        exp_stall = r ? 6'b000000 : ex ? 6'b001111 : id ? 6'b000111 : 6'b000000;
        @(posedge clk);
        if (r) begin
            m_len = 0; m_state = 0; m_to = 0; m_id = 0; m_ex = 0;
        end else begin
            m_state = ex ? 2 : (id ? 1 : 0);
            if (id || ex) begin
                m_len = (m_len >= 65535) ? 65535 : m_len + 1;
                if (m_len == WDOG) m_to = 1;
            end else begin
                m_len = 0;
            end
            if (ex) m_ex = (m_ex >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ex + 1;
            else if (id) m_id = (m_id >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_id + 1;
            if (c) begin
                m_to = 0; m_id = 0; m_ex = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        apply(0, 1, 0, 1);
        checks++;
        if (obs_stall !== 6'b000000) begin
            errors++; $display("FAIL reset_stall_mask got %b want 000000", obs_stall);
        end
        apply(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0);
            checks++;
            if (obs_stall !== 6'b000000 || bus.state !== 2'b00 || bus.stall_len !== 16'd0 ||
                bus.stall_timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got stall %b state %b len %0d to %b want 000000 00 0 0",
                         i, obs_stall, bus.state, bus.stall_len, bus.stall_timeout);
            end
`ifdef PIPE_CTRL_PERF_EN
            checks++;
            if (bus.id_stall_cnt !== 32'd0 || bus.ex_stall_cnt !== 32'd0) begin
                errors++; $display("FAIL reset_counters got %0d %0d want 0 0", bus.id_stall_cnt, bus.ex_stall_cnt);
            end
`endif
            $display("reset idle cyc %0d stall %b state %b len %0d", i, obs_stall, bus.state, bus.stall_len);
        end
    endtask

    task automatic test_id_run();
        logic [15:0] want_len [4] = '{16'd1, 16'd2, 16'd3, 16'd0};
        logic [1:0]  want_st  [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            apply(i < 3, 0, 0, 0);
            checks++;
            if (obs_stall !== ((i < 3) ? 6'b000111 : 6'b000000) || bus.stall_len !== want_len[i] ||
                bus.state !== want_st[i]) begin
                errors++;
                $display("FAIL id_run cyc %0d got stall %b len %0d state %b want len %0d state %b",
                         i, obs_stall, bus.stall_len, bus.state, want_len[i], want_st[i]);
            end
            $display("id_run cyc %0d stall %b state %b len %0d", i, obs_stall, bus.state, bus.stall_len);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.id_stall_cnt !== 32'd3) begin
            errors++; $display("FAIL id_run_cnt got %0d want 3", bus.id_stall_cnt);
        end
`endif
    endtask

    task automatic test_priority();
        logic [5:0] want [3] = '{6'b001111, 6'b001111, 6'b000111};
        apply(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, i < 2, 0, 0);
            checks++;
            if (obs_stall !== want[i] || bus.state !== ((i < 2) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL priority cyc %0d got stall %b state %b want %b", i, obs_stall, bus.state, want[i]);
            end
            $display("priority cyc %0d stall %b state %b len %0d", i, obs_stall, bus.state, bus.stall_len);
        end
        checks++;
        if (bus.stall_len !== 16'd3) begin
            errors++; $display("FAIL priority_len got %0d want 3", bus.stall_len);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.ex_stall_cnt !== 32'd2 || bus.id_stall_cnt !== 32'd1) begin
            errors++; $display("FAIL priority_cnt got ex %0d id %0d want 2 1", bus.ex_stall_cnt, bus.id_stall_cnt);
        end
`endif
        apply(0, 0, 0, 0);
    endtask

    task automatic test_watchdog();
        apply(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            apply(0, 1, 0, 0);
            checks++;
            if (bus.stall_timeout !== (i >= 3) || bus.stall_len !== 16'(i + 1)) begin
                errors++;
                $display("FAIL watchdog cyc %0d got to %b len %0d want to %b len %0d",
                         i, bus.stall_timeout, bus.stall_len, (i >= 3), i + 1);
            end
            $display("watchdog cyc %0d to %b len %0d", i, bus.stall_timeout, bus.stall_len);
        end
        apply(0, 0, 0, 0);
        checks++;
        if (bus.stall_timeout !== 1'b1 || obs_stall !== 6'b000000) begin
            errors++; $display("FAIL watchdog_sticky got to %b stall %b want 1 000000", bus.stall_timeout, obs_stall);
        end
        apply(0, 0, 1, 0);
        checks++;
        if (bus.stall_timeout !== 1'b0) begin
            errors++; $display("FAIL watchdog_clr got %b want 0", bus.stall_timeout);
        end
        // clr during an active run leaves the run length untouched
        apply(1, 0, 0, 0);
        apply(1, 0, 1, 0);
        checks++;
        if (bus.stall_len !== 16'd2 || bus.state !== 2'b01) begin
            errors++; $display("FAIL clr_keeps_run got len %0d state %b want 2 01", bus.stall_len, bus.state);
        end
        apply(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_stall();
        apply(0, 1, 0, 0);
        apply(0, 1, 0, 1);
        checks++;
        if (obs_stall !== 6'b000000) begin
            errors++; $display("FAIL rst_mid_stall_comb got %b want 000000", obs_stall);
        end
        checks++;
        if (bus.state !== 2'b00 || bus.stall_len !== 16'd0 || bus.stall_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stall_regs got state %b len %0d to %b want 00 0 0",
                     bus.state, bus.stall_len, bus.stall_timeout);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.ex_stall_cnt !== 32'd0 || bus.id_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_mid_stall_cnt got %0d %0d want 0 0", bus.ex_stall_cnt, bus.id_stall_cnt);
        end
`endif
        apply(0, 1, 0, 0);
        checks++;
        if (bus.stall_len !== 16'd1) begin
            errors++; $display("FAIL rst_restart_len got %0d want 1", bus.stall_len);
        end
        $display("reset mid-stall state %b len %0d", bus.state, bus.stall_len);
        apply(0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit id, ex, c, r;
        for (int i = 0; i < 400; i++) begin
            id = ($urandom_range(0, 99) < 55);
            ex = ($urandom_range(0, 99) < 35);
            c  = ($urandom_range(0, 99) < 6);
            r  = ($urandom_range(0, 99) < 2);
            apply(id, ex, c, r);
            checks++;
            if (obs_stall !== exp_stall || bus.state !== 2'(m_state) || bus.stall_len !== 16'(m_len) ||
                bus.stall_timeout !== m_to) begin
                errors++;
                $display("FAIL random cyc %0d got stall %b state %b len %0d to %b want %b %0d %0d %b",
                         i, obs_stall, bus.state, bus.stall_len, bus.stall_timeout,
                         exp_stall, m_state, m_len, m_to);
            end
`ifdef PIPE_CTRL_PERF_EN
            checks++;
            if (bus.id_stall_cnt !== 32'(m_id) || bus.ex_stall_cnt !== 32'(m_ex)) begin
                errors++;
                $display("FAIL random_cnt cyc %0d got id %0d ex %0d want %0d %0d",
                         i, bus.id_stall_cnt, bus.ex_stall_cnt, m_id, m_ex);
            end
`endif
            $display("random cyc %0d id %0b ex %0b clr %0b rst %0b stall %b state %b len %0d to %b",
                     i, id, ex, c, r, obs_stall, bus.state, bus.stall_len, bus.stall_timeout);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_saturation();
        apply(0, 0, 0, 0);
        @(negedge clk);
        force dut.ex_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.ex_cnt_reg;
        m_ex = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 0);
            checks++;
            if (bus.ex_stall_cnt !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL ex_cnt_sat cyc %0d got %h want ffffffff", i, bus.ex_stall_cnt);
            end
            $display("saturation cyc %0d ex_cnt %h", i, bus.ex_stall_cnt);
        end
        apply(0, 0, 0, 0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.stallreq_from_id = 1'b0;
        bus.stallreq_from_ex = 1'b0;
        bus.clr = 1'b0;
        m_len = 0; m_state = 0; m_to = 0; m_id = 0; m_ex = 0;
        test_reset();
        test_id_run();
        test_priority();
        test_watchdog();
        test_reset_mid_stall();
`ifdef PIPE_CTRL_PERF_EN
        test_saturation();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WDOG_LIMIT, default 64, consecutive stalled cycles that raise stall_timeout (legal 1..65535).
REQ-002 clk  input  1  pipeline clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallreq_from_id  input  1  ID stage requests a stall (load-use or operand hazard).
REQ-005 stallreq_from_ex  input  1  EX stage requests a stall (multi-cycle operation busy).
REQ-006 clr  input  1  synchronous clear of stall_timeout and performance counters.
REQ-007 stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-008 state  output  2  registered stall source: 00 RUN, 01 STALL_ID, 10 STALL_EX.
REQ-009 stall_len  output  16  length of the current consecutive stall run, registered.
REQ-010 stall_timeout  output  1  sticky watchdog flag.
REQ-011 id_stall_cnt, ex_stall_cnt  output  32 each  performance counters; present only with PIPE_CTRL_PERF_EN.

Function
REQ-012 stall SHALL be combinational from the inputs, zero added latency: ex request -> 6'b001111; else id request -> 6'b000111; else 6'b000000.
REQ-013 Simultaneous id and ex requests SHALL resolve to the ex pattern (EX priority, since older instruction).
REQ-014 Resulting contract: id-only request holds PC, IF/ID and ID/EX inputs and inserts one bubble into EX per cycle (stall[2]=1, stall[3]=0); ex request additionally holds EX, bubble into MEM.
REQ-015 state SHALL register, each posedge, the source selected that cycle: RUN if no request, STALL_EX if ex request, else STALL_ID; any state reaches any other in one cycle.
REQ-016 stall_len SHALL increment on each posedge with any request, saturate at 16'hFFFF, and load 0 on a cycle with no request; a direct STALL_ID<->STALL_EX change continues the run.
REQ-017 stall_timeout SHALL set on the posedge where stall_len would become equal to WDOG_LIMIT and SHALL remain set until rst or clr.
REQ-018 clr SHALL clear stall_timeout and counters on the next posedge; clr has priority over a same-cycle set/increment; clr SHALL NOT affect state or stall_len.
REQ-019 stall SHALL never depend on stall_timeout (watchdog is observational only).

Reset
REQ-020 While rst=1, stall SHALL be forced to 6'b000000 regardless of requests.
REQ-021 On posedge with rst=1: state=RUN, stall_len=0, stall_timeout=0, id_stall_cnt=0, ex_stall_cnt=0.
REQ-022 Reset asserted mid-stall SHALL abort the run; first post-reset cycle counts from stall_len=0.

Configuration
REQ-023 Macro PIPE_CTRL_PERF_EN defined: id_stall_cnt counts cycles resolved STALL_ID, ex_stall_cnt counts cycles resolved STALL_EX, each 32-bit saturating at 32'hFFFFFFFF.
REQ-024 Macro PIPE_CTRL_PERF_EN undefined: both counter ports and their registers are absent; all other behaviour identical.

Verification
REQ-025 Reset then idle 5 cycles -> stall=000000, state=00, stall_len=0 throughout.
REQ-026 id request 3 cycles then release -> stall=000111 for 3 cycles, stall_len 1,2,3 then 0; state 01 x3 then 00; id_stall_cnt=3 (PERF_EN).
REQ-027 id and ex asserted together 2 cycles, then id only 1 cycle -> stall 001111,001111,000111; stall_len=3; ex_stall_cnt=2, id_stall_cnt=1.
REQ-028 WDOG_LIMIT=4, ex request held 6 cycles -> stall_timeout rises on 4th posedge, stays 1 after release; clr pulse -> 0 next cycle.
REQ-029 rst asserted during 2nd cycle of ex stall -> stall=000000 same cycle; next posedge state=00, stall_len=0, counters 0.
REQ-030 Preload ex_stall_cnt to 32'hFFFFFFFE via forced stall run, hold ex request 3 more cycles -> counter stays 32'hFFFFFFFF.
